// File: rtl/acc_cpu_pkg.sv
// Shared opcodes, FSM state type and instruction field layout for the
// multi-cycle accumulator CPU core.
package acc_cpu_pkg;

    // Opcodes (instruction bits [15:12]); 11..14 execute as NOP
    localparam logic [3:0] OP_LDI  = 4'd0;
    localparam logic [3:0] OP_MOV  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_LD   = 4'd7;
    localparam logic [3:0] OP_ST   = 4'd8;
    localparam logic [3:0] OP_BEQZ = 4'd9;
    localparam logic [3:0] OP_JMP  = 4'd10;
    localparam logic [3:0] OP_HALT = 4'd15;

    // Instruction field positions
    localparam int OP_LSB  = 12;
    localparam int OP_W    = 4;
    localparam int RD_LSB  = 9;
    localparam int RS1_LSB = 6;
    localparam int RS2_LSB = 3;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 8;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    // Opcodes that write rd during EXEC (LDI and the ALU group)
    function automatic logic writes_in_exec(input logic [3:0] op);
        return op <= OP_SRL;
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: MOV/ADD/SUB/AND/OR/SRL, modulo 2^DW, with zero detect.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    op,
    output logic [DW-1:0] result,
    output logic          zero
);

    localparam int SHW = $clog2(DW);

    // Operation select; unknown opcodes pass a through
    always_comb begin
        // NOTE: default first so every path assigns result and no latch is inferred.
        result = a;
        case (op)
            OP_MOV:  result = b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_SRL:  result = a >> b[SHW-1:0];
            default: result = a;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle CPU core: FETCH/EXEC/MEM/HALT sequencer, program counter,
// register file, and req/ack instruction and data ports.
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NREG = 8,
    parameter int PCW  = 8,
    parameter int IW   = 16
) (
    input  logic           CLK,
    input  logic           RESET_N,
    output logic           imem_req,
    output logic [PCW-1:0] imem_addr,
    input  logic           imem_ack,
    input  logic [IW-1:0]  imem_rdata,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic [DW-1:0]  dmem_addr,
    output logic [DW-1:0]  dmem_wdata,
    input  logic           dmem_ack,
    input  logic [DW-1:0]  dmem_rdata,
    output logic [DW-1:0]  alu_result,
    output logic           zero,
    output logic           halted
);

    localparam int RAW = $clog2(NREG);

    state_t          state;
    logic [IW-1:0]   instr;
    logic [PCW-1:0]  pc;
    logic [DW-1:0]   regs [NREG];

    logic [3:0]      op;
    logic [RAW-1:0]  rd_idx;
    logic [RAW-1:0]  rs1_idx;
    logic [RAW-1:0]  rs2_idx;
    logic [IMM_W-1:0] imm;
    logic [DW-1:0]   imm_val;
    logic [DW-1:0]   rs1_val;
    logic [DW-1:0]   rs2_val;
    logic [DW-1:0]   alu_y;
    logic            alu_z;
    logic            rf_we;
    logic [DW-1:0]   wr_data;
    logic            wr_zero;
    logic [PCW-1:0]  pc_inc;
    logic [PCW-1:0]  br_target;

    // Decode from the latched instruction; upper register-field bits ignored
    assign op        = instr[OP_LSB +: OP_W];
    assign rd_idx    = instr[RD_LSB +: RAW];
    assign rs1_idx   = instr[RS1_LSB +: RAW];
    assign rs2_idx   = instr[RS2_LSB +: RAW];
    assign imm       = instr[IMM_LSB +: IMM_W];
    assign imm_val   = DW'(imm);
    assign rs1_val   = regs[rs1_idx];
    assign rs2_val   = regs[rs2_idx];
    assign pc_inc    = pc + PCW'(1);
    assign br_target = imm[PCW-1:0];
    assign imem_addr = pc;

    acc_cpu_alu #(.DW(DW)) u_alu (
        .a      (rs1_val),
        .b      (rs2_val),
        .op     (op),
        .result (alu_y),
        .zero   (alu_z)
    );

    // Register write port: ALU/LDI in EXEC, load data on the MEM ack
    always_comb begin
        rf_we   = 1'b0;
        wr_data = alu_y;
        wr_zero = alu_z;
        if (state == S_EXEC && writes_in_exec(op)) begin
            rf_we = 1'b1;
            if (op == OP_LDI) begin
                wr_data = imm_val;
                wr_zero = (imm_val == '0);
            end
        end else if (state == S_MEM && dmem_ack && !dmem_we) begin
            rf_we   = 1'b1;
            wr_data = dmem_rdata;
            wr_zero = (dmem_rdata == '0);
        end
    end

    // Register file, last-written value and Z flag
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            // NOTE: the register file is reset on purpose: software relies on every register reading 0 after reset.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            alu_result <= '0;
            zero       <= 1'b0;
        end else if (rf_we) begin
            regs[rd_idx] <= wr_data;
            alu_result   <= wr_data;
            zero         <= wr_zero;
        end
    end

    // Sequencer: state, PC, instruction latch and registered port outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= S_FETCH;
            pc         <= '0;
            instr      <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            halted     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                S_FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        instr    <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op)
                        OP_LD, OP_ST: begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= (op == OP_ST);
                            dmem_addr  <= rs1_val;
                            dmem_wdata <= rs2_val;
                            state      <= S_MEM;
                        end
                        OP_BEQZ: begin
                            pc       <= zero ? br_target : pc_inc;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        OP_JMP: begin
                            pc       <= br_target;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        default: begin
                            pc       <= pc_inc;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        pc       <= pc_inc;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    halted <= 1'b1;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: doc/acc_cpu_core.md
# acc_cpu_core

Parametrised multi-cycle CPU core, successor to the single-cycle accumulator datapath. It fetches instructions over a req/ack port and executes register-to-register ALU operations, immediate loads, loads/stores over a separate req/ack data port, conditional and unconditional branches, and halt. It sits between the instruction ROM/SRAM and the data SRAM and exposes its result and flag for the top-level output pins.

## Interface
Parameters:
- DW, 8: datapath and register width (≥ 4).
- NREG, 8: register-file depth, power of 2, 2..8; register fields are 3 bits, and upper unused bits are ignored.
- PCW, 8: program-counter / instruction-address width (≤ 8).
- IW, 16: instruction width (fixed 16 in this generation).

Ports:
- CLK  in  1  single clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PCW  fetch address (= PC).
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  in  IW  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  DW  data address (= rs1 value).
- dmem_wdata  out  DW  store data (= rs2 value).
- dmem_ack  in  1  access complete; dmem_rdata valid on loads.
- dmem_rdata  in  DW  load data.
- alu_result  out  DW  last value written to any register.
- zero  out  1  Z flag.
- halted  out  1  core is in HALT.

## Operation
- Instruction fields: op = [15:12], rd = [11:9], rs1 = [8:6], rs2 = [5:3], imm = [7:0].
- Opcodes:
  - 0 LDI: rd ← zero-extended imm (truncated if DW < 8).
  - 1 MOV: rd ← rs2.
  - 2 ADD, 3 SUB (rs1 − rs2, two's complement), 4 AND, 5 OR.
  - 6 SRL: rd ← rs1 >> rs2[$clog2(DW)-1:0], logical.
  - 7 LD: rd ← mem[rs1].
  - 8 ST: mem[rs1] ← rs2.
  - 9 BEQZ: if Z, PC ← imm[PCW-1:0].
  - 10 JMP: PC ← imm[PCW-1:0].
  - 15 HALT.
  - 11–14: NOP.
- Arithmetic is modulo 2^DW; carry is discarded.
- Z is updated only by opcodes 0–7 and equals (written value == 0).
- alu_result updates on every register write.
- PC: +1 per non-taken instruction, wrapping modulo 2^PCW. PC = 2^PCW−1 followed by +1 gives 0.
- FSM states: FETCH, EXEC, MEM, HALT.
  - FETCH: imem_req = 1. On imem_ack, latch the instruction and go to EXEC.
  - EXEC, opcodes 0–6: write rd and update Z, PC+1, go to FETCH.
  - EXEC, opcodes 7/8: go to MEM.
  - EXEC, opcodes 9/10: update PC, go to FETCH.
  - EXEC, NOP: PC+1, go to FETCH.
  - EXEC, HALT: go to HALT; PC is not incremented.
  - MEM: dmem_req = 1, with dmem_we/addr/wdata stable. On dmem_ack, a LD writes rd and updates Z. Then PC+1, go to FETCH.
  - HALT: terminal; halted = 1, no requests. Only reset exits.
- Register file: NREG × DW, one write per cycle. Reads are combinational from the latched instruction.

## Timing
- Reset values: all registers 0, PC 0, Z 0, alu_result 0, imem_req 0, dmem_req 0, dmem_we 0, dmem_addr 0, dmem_wdata 0, halted 0, state FETCH.
- imem_req rises on the first CLK edge after RESET_N deasserts.
- A req stays high until the cycle its ack is sampled. Ack in the same cycle as req is legal (zero wait).
- Req is low for at least one cycle between consecutive fetches (the EXEC cycle).
- Ack while req is low is ignored.
- Latency with zero-wait memories: ALU/branch/NOP take 2 cycles; LD/ST take 3 cycles. Each memory wait cycle adds 1.
- A register written in EXEC/MEM is visible to the next instruction's EXEC.
- RESET_N assertion mid-operation: all outputs are forced to reset values immediately (asynchronously), and any in-flight request is abandoned.

## Structure
- Package acc_cpu_pkg: opcode localparams, state enum, instruction field positions.
- Sub-module acc_cpu_alu: combinational, parametrised by DW. Inputs are a, b, and op; outputs are result and zero. It implements MOV/ADD/SUB/AND/OR/SRL.
- The register file, FSM, and PC live in the top module.

## Test plan
- Reset release with zero-wait memories: first fetch at imem_addr 0 on cycle 1. LDI r1, 0x05 gives alu_result = 0x05, zero = 0.
- Program r1 = 5, r2 = 5, SUB r3 ← r1 − r2, then BEQZ 0x20: zero = 1 and next imem_addr = 0x20. Repeat with r2 = 3: r3 = 0x02 and the branch is not taken.
- Shift: r1 = 0x80, r2 = 3, SRL gives 0x10. ADD 0xFF + 0x01 gives 0x00 with zero = 1.
- ST mem[0x10] ← 0xA5 then LD r4 ← mem[0x10], with 3-cycle dmem_ack delay: dmem_req is held 3 cycles, the store has dmem_we = 1, r4 = 0xA5, and each instruction takes 3 extra cycles.
- PC wrap: JMP 0xFF with a NOP at 0xFF gives next fetch address 0x00. HALT gives halted = 1 and no further imem_req for 20 cycles.
- RESET_N pulsed low while dmem_req is high: dmem_req drops in the same cycle, then fetch restarts at address 0 and all registers read 0.
